// File: rtl/paddle_tracker.sv
// rtl/paddle_tracker.sv - per-frame paddle position filter: clamp, deadband, rate-limited proportional step.
module paddle_tracker #(
  parameter int SCREEN_H = 480,
  parameter int PADDLE_H = 64,
  parameter int DEAD     = 4,
  parameter int SHIFT    = 2,
  parameter int MAX_STEP = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic [9:0] pos_player1,
  input  logic [9:0] pos_player2,
  output logic [9:0] paddle1_y,
  output logic [9:0] paddle2_y,
  output logic       update
);

  localparam logic [9:0] YMAX    = 10'(SCREEN_H - PADDLE_H);
  localparam logic [9:0] YMID    = YMAX >> 1;
  localparam logic [9:0] DEAD_V  = 10'(DEAD);
  localparam logic [9:0] MAX_V   = 10'(MAX_STEP);

  typedef enum logic [1:0] {S_IDLE, S_P1, S_P2, S_COMMIT} state_t;

  state_t r_state;
  state_t w_next;

  logic [9:0] r_raw1, r_raw2, r_acc1, r_acc2, r_paddle1_y, r_paddle2_y;
  logic       r_update;

  logic [9:0]        w_raw, w_acc, w_target, w_abs, w_mag, w_acc_next;
  logic signed [10:0] w_diff, w_neg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (frame_tick) w_next = S_P1;
      S_P1:     w_next = S_P2;
      S_P2:     w_next = S_COMMIT;
      S_COMMIT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Shared datapath: the player being processed is selected by the state.
  always_comb begin
    w_raw    = (r_state == S_P2) ? r_raw2 : r_raw1;
    w_acc    = (r_state == S_P2) ? r_acc2 : r_acc1;
    w_target = (w_raw > YMAX) ? YMAX : w_raw;
    w_diff   = $signed({1'b0, w_target}) - $signed({1'b0, w_acc});
    w_neg    = -w_diff;
    w_abs    = w_diff[10] ? w_neg[9:0] : w_diff[9:0];
    w_mag    = w_abs >> SHIFT;
    if (w_mag == 10'd0) w_mag = 10'd1;
    if (w_mag > MAX_V)  w_mag = MAX_V;
    if (w_abs <= DEAD_V)  w_acc_next = w_acc;
    else if (w_diff[10])  w_acc_next = w_acc - w_mag;
    else                  w_acc_next = w_acc + w_mag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_raw1      <= 10'd0;
      r_raw2      <= 10'd0;
      r_acc1      <= YMID;
      r_acc2      <= YMID;
      r_paddle1_y <= YMID;
      r_paddle2_y <= YMID;
      r_update    <= 1'b0;
    end else begin
      r_update <= (r_state == S_COMMIT);
      case (r_state)
        S_IDLE: if (frame_tick) begin
          r_raw1 <= pos_player1;
          r_raw2 <= pos_player2;
        end
        S_P1:     r_acc1 <= w_acc_next;
        S_P2:     r_acc2 <= w_acc_next;
        S_COMMIT: begin
          r_paddle1_y <= r_acc1;
          r_paddle2_y <= r_acc2;
        end
        default: ;
      endcase
    end
  end

  assign paddle1_y = r_paddle1_y;
  assign paddle2_y = r_paddle2_y;
  assign update    = r_update;

endmodule

// File: tb/tb_paddle_tracker.sv
// tb/tb_paddle_tracker.sv - directed and randomized checks of paddle_tracker against an arithmetic model.
module tb_paddle_tracker;

  logic       clk;
  logic       rst_n;
  logic       frame_tick;
  logic [9:0] pos_player1;
  logic [9:0] pos_player2;
  logic [9:0] paddle1_y;
  logic [9:0] paddle2_y;
  logic       update;

  int total = 0;
  int bad   = 0;
  int m_acc1, m_acc2, m_out1, m_out2;
  int max1;

  paddle_tracker dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .pos_player1 (pos_player1),
    .pos_player2 (pos_player2),
    .paddle1_y   (paddle1_y),
    .paddle2_y   (paddle2_y),
    .update      (update)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_step(input int acc, input int raw);
    int t, d, a, m;
    t = (raw > 416) ? 416 : raw;
    d = t - acc;
    a = (d < 0) ? -d : d;
    if (a <= 4) return acc;
    m = a / 4;
    if (m == 0) m = 1;
    if (m > 16) m = 16;
    return (d < 0) ? acc - m : acc + m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc1 = 208; m_acc2 = 208; m_out1 = 208; m_out2 = 208;
  endtask

  // Called just after a negedge; asserts reset mid-low-phase and checks asynchronous effect.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_p1"}, 32'(paddle1_y), 32'd208);
    chk({tag, "_p2"}, 32'(paddle2_y), 32'd208);
    chk({tag, "_upd"}, 32'(update), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Called just after a negedge; one accepted tick with full latency checks.
  task automatic tick(input string tag, input int r1, input int r2);
    pos_player1 = 10'(r1);
    pos_player2 = 10'(r2);
    frame_tick  = 1'b1;
    @(negedge clk);
    frame_tick  = 1'b0;
    pos_player1 = 10'($urandom_range(0, 1023));
    pos_player2 = 10'($urandom_range(0, 1023));
    m_acc1 = model_step(m_acc1, r1);
    m_acc2 = model_step(m_acc2, r2);
    @(negedge clk);
    chk({tag, "_upd_e1"}, 32'(update), 32'd0);
    @(negedge clk);
    chk({tag, "_upd_e2"}, 32'(update), 32'd0);
    chk({tag, "_hold_p1"}, 32'(paddle1_y), 32'(m_out1));
    @(negedge clk);
    m_out1 = m_acc1;
    m_out2 = m_acc2;
    chk({tag, "_upd_e3"}, 32'(update), 32'd1);
    chk({tag, "_p1"}, 32'(paddle1_y), 32'(m_out1));
    chk({tag, "_p2"}, 32'(paddle2_y), 32'(m_out2));
    @(negedge clk);
    chk({tag, "_upd_e4"}, 32'(update), 32'd0);
  endtask

  initial begin
    rst_n = 1'b1; frame_tick = 1'b0; pos_player1 = '0; pos_player2 = '0;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_p1", 32'(paddle1_y), 32'd208);
    chk("rst_p2", 32'(paddle2_y), 32'd208);
    chk("rst_upd", 32'(update), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Deadband and minimum step, both directions.
    tick("dead", 210, 213);
    chk("dead_p1_const", 32'(paddle1_y), 32'd208);
    chk("dead_p2_const", 32'(paddle2_y), 32'd209);
    tick("down1", 210, 204);
    chk("down1_p2_const", 32'(paddle2_y), 32'd208);

    // Clamp, rate limit and downward settle from reset.
    async_reset("rst_mid");
    tick("clamp0", 1023, 0);
    chk("clamp0_p1_const", 32'(paddle1_y), 32'd224);
    chk("clamp0_p2_const", 32'(paddle2_y), 32'd192);
    max1 = 0;
    for (int i = 0; i < 30; i++) begin
      tick("clamp", 1023, 0);
      if (int'(paddle1_y) > max1) max1 = int'(paddle1_y);
    end
    chk("clamp_settle_p1", 32'(paddle1_y), 32'd412);
    chk("clamp_settle_p2", 32'(paddle2_y), 32'd4);
    chk("clamp_never_over", 32'(max1 <= 416), 32'd1);

    // Ticks during processing are ignored; a tick while update is high is accepted.
    async_reset("rst_b");
    pos_player1 = 10'd500; pos_player2 = 10'd208; frame_tick = 1'b1;
    @(negedge clk);                 // E0 latched 500
    pos_player1 = 10'd0;            // tick still high at E1, E2
    @(negedge clk);
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);                 // after E3
    chk("busy_upd_e3", 32'(update), 32'd1);
    chk("busy_p1", 32'(paddle1_y), 32'd224);
    frame_tick = 1'b1;              // sampled at E4 with update high
    @(negedge clk);
    frame_tick = 1'b0;
    chk("busy_upd_e4", 32'(update), 32'd0);
    @(negedge clk);
    chk("busy_upd_e5", 32'(update), 32'd0);
    @(negedge clk);
    chk("busy_upd_e6", 32'(update), 32'd0);
    @(negedge clk);
    chk("busy_upd_e7", 32'(update), 32'd1);
    chk("busy_p1_second", 32'(paddle1_y), 32'd208);
    @(negedge clk);
    chk("busy_upd_e8", 32'(update), 32'd0);

    // Reset during P2 aborts the pass.
    pos_player1 = 10'd600; pos_player2 = 10'd100; frame_tick = 1'b1;
    @(negedge clk);                 // E0
    frame_tick = 1'b0;
    @(negedge clk);                 // after E1, state P2
    async_reset("rst_p2");
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_upd", 32'(update), 32'd0);
      chk("abort_p1", 32'(paddle1_y), 32'd208);
      @(negedge clk);
    end
    tick("fresh", 1023, 0);
    chk("fresh_p1_const", 32'(paddle1_y), 32'd224);
    chk("fresh_p2_const", 32'(paddle2_y), 32'd192);

    // Randomized frames with random idle gaps.
    for (int i = 0; i < 40; i++) begin
      int g;
      g = $urandom_range(0, 3);
      for (int k = 0; k < g; k++) @(negedge clk);
      if (($urandom_range(0, 3)) == 0)
        tick("rnd", $urandom_range(180, 240), $urandom_range(0, 1023));
      else
        tick("rnd", $urandom_range(0, 1023), $urandom_range(0, 1023));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
